// File: rtl/mps_axil_cmd_master.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// mps_axil_cmd_master
//
// AXI4-Lite master that turns single commands from a local command source
// (front-panel or serial bridge) into one register write or read on the MPS
// system register slave. Only one transaction is in flight at a time, and the
// result is handed back on a valid/ready response port.
//
// A transaction that the slave never finishes is cut off after TIMEOUT_CYC
// cycles. All AXI valids and readies are dropped, and a timeout error is
// reported, so a stuck slave cannot hang the command source.
//
// Parameters
//   C_M_AXI_DATA_WIDTH  data width, only 32 is supported
//   C_M_AXI_ADDR_WIDTH  byte address width (7 covers the 20-word map)
//   TIMEOUT_CYC         cycles from command accept to forced completion
//                       (minimum 4, maximum 65536)
//
// Ports
//   i_clk, i_rst        clock (rising edge), asynchronous active-low reset
//   i_cmd_*/o_cmd_ready command request; accepted when valid & ready
//   o_rsp_*/i_rsp_ready response; consumed when valid & ready
//                       o_rsp_err: 00 OKAY, 01 SLVERR/DECERR, 10 timeout
//   o_busy              high whenever the FSM is not idle
//   m00_axi_*           AXI4-Lite master channels AW, W, B, AR, R
//
// All outputs are registered. Accepting a command in cycle T raises
// awvalid/wvalid or arvalid in T+1.
// ----------------------------------------------------------------------------
module mps_axil_cmd_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 7,
    parameter int TIMEOUT_CYC        = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst,

    // command port
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic                          i_cmd_wr,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] i_cmd_wdata,

    // response port
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [1:0]                    o_rsp_err,
    output logic                          o_busy,

    // AXI4-Lite write address
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m00_axi_awaddr,
    output logic [2:0]                    m00_axi_awprot,
    output logic                          m00_axi_awvalid,
    input  logic                          m00_axi_awready,

    // AXI4-Lite write data
    output logic [C_M_AXI_DATA_WIDTH-1:0] m00_axi_wdata,
    output logic [3:0]                    m00_axi_wstrb,
    output logic                          m00_axi_wvalid,
    input  logic                          m00_axi_wready,

    // AXI4-Lite write response
    input  logic [1:0]                    m00_axi_bresp,
    input  logic                          m00_axi_bvalid,
    output logic                          m00_axi_bready,

    // AXI4-Lite read address
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [2:0]                    m00_axi_arprot,
    output logic                          m00_axi_arvalid,
    input  logic                          m00_axi_arready,

    // AXI4-Lite read data
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [1:0]                    m00_axi_rresp,
    input  logic                          m00_axi_rvalid,
    output logic                          m00_axi_rready
);

    // ------------------------------------------------------------------------
    // constants
    // ------------------------------------------------------------------------
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    // The counter starts at 0 in the first active cycle. When it reads
    // TIMEOUT_CYC-1, TIMEOUT_CYC active cycles have elapsed. Leaving on that
    // edge puts o_rsp_valid exactly TIMEOUT_CYC+1 cycles after accept.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    // Word alignment: the two byte-lane bits are always issued as zero.
    localparam logic [AW-1:0] ADDR_MASK = {{(AW-2){1'b1}}, 2'b00};

    localparam logic [1:0] ERR_OKAY    = 2'b00;
    localparam logic [1:0] ERR_SLAVE   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Protection and strobes are fixed: unprivileged secure data access,
    // full-word writes only.
    assign m00_axi_awprot = 3'b000;
    assign m00_axi_arprot = 3'b000;
    assign m00_axi_wstrb  = 4'hF;

    // ------------------------------------------------------------------------
    // state
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_B,
        S_RD_AR,
        S_RD_R,
        S_RSP
    } state_t;

    state_t      state;
    logic        aw_done;   // AW handshake already happened in S_WR
    logic        w_done;    // W handshake already happened in S_WR
    logic [15:0] to_cnt;    // active cycles since accept

    // ------------------------------------------------------------------------
    // handshake decode
    // ------------------------------------------------------------------------
    logic cmd_acc;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_ok, w_ok;
    logic timeout;

    assign cmd_acc = i_cmd_valid & o_cmd_ready;
    assign aw_hs   = m00_axi_awvalid & m00_axi_awready;
    assign w_hs    = m00_axi_wvalid  & m00_axi_wready;
    assign b_hs    = m00_axi_bvalid  & m00_axi_bready;
    assign ar_hs   = m00_axi_arvalid & m00_axi_arready;
    assign r_hs    = m00_axi_rvalid  & m00_axi_rready;

    // A channel counts as done if it completed earlier or completes now.
    // This covers both channels finishing in the same cycle or in either order.
    assign aw_ok   = aw_done | aw_hs;
    assign w_ok    = w_done  | w_hs;

    assign timeout = (to_cnt == TO_LAST);

    // Only resp[1] separates OKAY/EXOKAY from SLVERR/DECERR.
    logic unused_resp_lsb;
    assign unused_resp_lsb = m00_axi_bresp[0] ^ m00_axi_rresp[0];

    // ------------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state           <= S_IDLE;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            to_cnt          <= '0;
            o_cmd_ready     <= 1'b0;
            o_rsp_valid     <= 1'b0;
            o_rsp_rdata     <= '0;
            o_rsp_err       <= ERR_OKAY;
            o_busy          <= 1'b0;
            m00_axi_awaddr  <= '0;
            m00_axi_awvalid <= 1'b0;
            m00_axi_wdata   <= '0;
            m00_axi_wvalid  <= 1'b0;
            m00_axi_bready  <= 1'b0;
            m00_axi_araddr  <= '0;
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b0;
        end else begin
            case (state)
                // ------------------------------------------------------------
                S_IDLE: begin
                    if (cmd_acc) begin
                        o_cmd_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        to_cnt      <= '0;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        if (i_cmd_wr) begin
                            m00_axi_awaddr  <= i_cmd_addr & ADDR_MASK;
                            m00_axi_wdata   <= i_cmd_wdata;
                            m00_axi_awvalid <= 1'b1;
                            m00_axi_wvalid  <= 1'b1;
                            state           <= S_WR;
                        end else begin
                            m00_axi_araddr  <= i_cmd_addr & ADDR_MASK;
                            m00_axi_arvalid <= 1'b1;
                            state           <= S_RD_AR;
                        end
                    end else begin
                        // Also covers the first cycle after reset release.
                        o_cmd_ready <= 1'b1;
                    end
                end

                // ------------------------------------------------------------
                S_WR: begin
                    to_cnt <= to_cnt + 16'd1;
                    if (aw_hs) begin
                        m00_axi_awvalid <= 1'b0;
                        aw_done         <= 1'b1;
                    end
                    if (w_hs) begin
                        m00_axi_wvalid <= 1'b0;
                        w_done         <= 1'b1;
                    end
                    if (aw_ok && w_ok) begin
                        m00_axi_bready <= 1'b1;
                        state          <= S_WR_B;
                    end else if (timeout) begin
                        m00_axi_awvalid <= 1'b0;
                        m00_axi_wvalid  <= 1'b0;
                        o_rsp_valid     <= 1'b1;
                        o_rsp_rdata     <= '0;
                        o_rsp_err       <= ERR_TIMEOUT;
                        state           <= S_RSP;
                    end
                end

                // ------------------------------------------------------------
                // A beat that lands in the timeout cycle is still taken as the
                // real answer. Reporting a good completion beats a timeout.
                S_WR_B: begin
                    to_cnt <= to_cnt + 16'd1;
                    if (b_hs) begin
                        m00_axi_bready <= 1'b0;
                        o_rsp_valid    <= 1'b1;
                        o_rsp_rdata    <= '0;
                        o_rsp_err      <= m00_axi_bresp[1] ? ERR_SLAVE : ERR_OKAY;
                        state          <= S_RSP;
                    end else if (timeout) begin
                        m00_axi_bready <= 1'b0;
                        o_rsp_valid    <= 1'b1;
                        o_rsp_rdata    <= '0;
                        o_rsp_err      <= ERR_TIMEOUT;
                        state          <= S_RSP;
                    end
                end

                // ------------------------------------------------------------
                S_RD_AR: begin
                    to_cnt <= to_cnt + 16'd1;
                    if (ar_hs) begin
                        m00_axi_arvalid <= 1'b0;
                        m00_axi_rready  <= 1'b1;
                        state           <= S_RD_R;
                    end else if (timeout) begin
                        m00_axi_arvalid <= 1'b0;
                        o_rsp_valid     <= 1'b1;
                        o_rsp_rdata     <= '0;
                        o_rsp_err       <= ERR_TIMEOUT;
                        state           <= S_RSP;
                    end
                end

                // ------------------------------------------------------------
                S_RD_R: begin
                    to_cnt <= to_cnt + 16'd1;
                    if (r_hs) begin
                        m00_axi_rready <= 1'b0;
                        o_rsp_valid    <= 1'b1;
                        if (m00_axi_rresp[1]) begin
                            o_rsp_rdata <= '0;
                            o_rsp_err   <= ERR_SLAVE;
                        end else begin
                            o_rsp_rdata <= m00_axi_rdata;
                            o_rsp_err   <= ERR_OKAY;
                        end
                        state <= S_RSP;
                    end else if (timeout) begin
                        m00_axi_rready <= 1'b0;
                        o_rsp_valid    <= 1'b1;
                        o_rsp_rdata    <= '0;
                        o_rsp_err      <= ERR_TIMEOUT;
                        state          <= S_RSP;
                    end
                end

                // ------------------------------------------------------------
                // The response fields are held until consumed. o_cmd_ready
                // rises together with the return to idle, so a command
                // presented during this state is never accepted.
                S_RSP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        o_cmd_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state           <= S_IDLE;
                    o_cmd_ready     <= 1'b0;
                    o_busy          <= 1'b0;
                    o_rsp_valid     <= 1'b0;
                    m00_axi_awvalid <= 1'b0;
                    m00_axi_wvalid  <= 1'b0;
                    m00_axi_bready  <= 1'b0;
                    m00_axi_arvalid <= 1'b0;
                    m00_axi_rready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mps_axil_cmd_master.md
# mps_axil_cmd_master

AXI4-Lite master that issues single register writes and reads toward the MPS system register slave (20 x 32-bit word map) from a simple command/response port. It sits between a local command source (front-panel or serial command bridge) and the MPS system AXI4-Lite slave. It handles AW/W channel independence, B/R response capture, and a bounded timeout so that a stuck slave can never hang the command source.

## Interface
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 is supported
- C_M_AXI_ADDR_WIDTH, 7, byte address width ($clog2(20)+2)
- TIMEOUT_CYC, 1024, cycles allowed from command accept to AXI completion; minimum 4

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  reset; one clock; reset is asynchronous and active-low
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  command accepted when valid & ready
- i_cmd_wr  in  1  1 = write, 0 = read
- i_cmd_addr  in  ADDR_W  byte address; bits [1:0] ignored, issued as 0
- i_cmd_wdata  in  32  write data
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  response consumed when valid & ready
- o_rsp_rdata  out  32  read data; 0 for writes and errors
- o_rsp_err  out  2  00 OKAY, 01 SLVERR/DECERR, 10 timeout
- o_busy  out  1  high in every state except IDLE
- m00_axi_aw{addr,prot,valid,ready}, m00_axi_w{data,strb,valid,ready}, m00_axi_b{resp,valid,ready}, m00_axi_ar{addr,prot,valid,ready}, m00_axi_r{data,resp,valid,ready}  standard AXI4-Lite master channels; awprot/arprot = 3'b000, wstrb = 4'hF

## Operation
- States: IDLE, WR (AW+W), WR_B, RD_AR, RD_R, RSP.
- IDLE: o_cmd_ready = 1. On accept, latch addr/data/type; go WR if i_cmd_wr else RD_AR.
- WR: awvalid and wvalid both high on entry; each drops independently the cycle after its own handshake; transition to WR_B once both handshakes have occurred (same or different cycles, either order).
- WR_B: bready = 1; on bvalid capture bresp, go RSP.
- RD_AR: arvalid = 1 until arready; then RD_R.
- RD_R: rready = 1; on rvalid capture rdata and rresp, go RSP.
- RSP: o_rsp_valid = 1 with stable rdata/err until i_rsp_ready; then IDLE.
- Error mapping: resp[1] = 1 -> err 01, rdata forced 0.
- Timeout: 16-bit counter cleared at accept, increments in WR/WR_B/RD_AR/RD_R; reaching TIMEOUT_CYC forces all valids/readies low, err 10, go RSP. Fault-recovery path only; a late B/R beat afterward is discarded (bready/rready low).
- Single outstanding transaction; no new command accepted before RSP completes.
- Reset mid-transaction: all AXI valids/readies and o_rsp_valid drop asynchronously; FSM to IDLE.

## Timing
- Reset values: o_cmd_ready 0 while in reset, 1 first cycle after release; all AXI valid/ready 0; addr/data/rdata 0; o_rsp_valid 0; o_rsp_err 00; o_busy 0.
- All outputs registered. Accept at cycle T -> awvalid/wvalid or arvalid high at T+1.
- Zero-wait slave write: AW/W handshake T+1, bready T+2, bvalid T+2, o_rsp_valid T+3, o_cmd_ready T+4 if i_rsp_ready at T+3.
- Zero-wait slave read: AR handshake T+1, R handshake T+2, o_rsp_valid T+3.
- Timeout: o_rsp_valid exactly TIMEOUT_CYC+1 cycles after accept.

## Test plan
- Write 0x1234_5678 to 0x08, slave zero-wait, OKAY -> awaddr 0x08, wdata 0x12345678, wstrb F, o_rsp_valid at T+3, err 00.
- Write with awready delayed 3 cycles, wready immediate -> wvalid drops at T+2, awvalid at T+5; single bvalid handshake; err 00.
- Read 0x0C (address in as 0x0F), slave returns 0xDEAD_BEEF OKAY -> araddr 0x0C, rdata 0xDEADBEEF, err 00; second read with rresp SLVERR -> rdata 0, err 01.
- Slave never asserts arready, TIMEOUT_CYC=16 -> arvalid low and o_rsp_valid at T+17, err 10; next command accepted normally.
- i_rsp_ready held low 10 cycles -> rsp fields stable, o_cmd_ready 0, cmd_valid ignored throughout.
- i_rst asserted while wvalid high -> all valids 0 immediately; after release o_cmd_ready 1, o_busy 0.
